// File: rtl/bus_stream_sink_if.sv
// Valid/ready/data stream bus between a slice output and the stream sink.
interface bus_stream_sink_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bus_stream_sink.sv
// Configurable stream consumer: drives ready with a backpressure pattern, checks data
// against an incrementing reference, counts beats/errors and flags protocol violations.
module bus_stream_sink #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned ERR_W     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int unsigned PERIOD    = 4,
   parameter bit          RESYNC    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic [WIDTH-1:0] init_i,
   bus_stream_sink_if.slave bus,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] beat_cnt_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic             err_flag_o,
   output logic [WIDTH-1:0] first_err_data_o,
   output logic [WIDTH-1:0] first_err_exp_o,
   output logic             proto_err_o
);

   localparam int unsigned PER_W = $clog2(PERIOD);
   localparam logic [PER_W-1:0] PerLast = PER_W'(PERIOD - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             flag_q, flag_d;
   logic [WIDTH-1:0] fed_q, fed_d;
   logic [WIDTH-1:0] fee_q, fee_d;
   logic             proto_q, proto_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [PER_W-1:0] per_q, per_d;
   // Previous RUN cycle stalled (valid without ready) and the data it held.
   logic             stall_q, stall_d;
   logic [WIDTH-1:0] pdata_q, pdata_d;

   logic [15:0]      lfsr_nxt;
   logic             xfer;
   logic             term;
   logic             mism;

   // Next-state logic: FSM, backpressure generators, scoreboard and protocol monitor.
   always_comb begin
      state_d  = state_q;
      ready_d  = 1'b0;
      exp_d    = exp_q;
      beat_d   = beat_q;
      err_d    = err_q;
      flag_d   = flag_q;
      fed_d    = fed_q;
      fee_d    = fee_q;
      proto_d  = proto_q;
      lfsr_d   = lfsr_q;
      per_d    = per_q;
      stall_d  = 1'b0;
      pdata_d  = pdata_q;
      lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      xfer     = 1'b0;
      term     = 1'b0;
      mism     = 1'b0;

      case (state_q)
         StRun: begin
            lfsr_d  = lfsr_nxt;
            per_d   = (per_q == PerLast) ? '0 : per_q + PER_W'(1);
            stall_d = bus.valid & ~ready_q;
            pdata_d = bus.data;

            // A stalled beat must stay valid with unchanged data.
            if (stall_q && (!bus.valid || (bus.data != pdata_q))) begin
               proto_d = 1'b1;
            end

            xfer = bus.valid & ready_q;
            if (xfer) begin
               mism   = (bus.data != exp_q);
               beat_d = beat_q + CNT_W'(1);
               term   = (len_i != '0) && (beat_q == len_i - CNT_W'(1));
               if (mism) begin
                  if (err_q != {ERR_W{1'b1}}) begin
                     err_d = err_q + ERR_W'(1);
                  end
                  if (!flag_q) begin
                     fed_d = bus.data;
                     fee_d = exp_q;
                  end
                  flag_d = 1'b1;
               end
               exp_d = (RESYNC && mism) ? bus.data + WIDTH'(1) : exp_q + WIDTH'(1);
            end

            if (term) begin
               state_d = StDone;
            end else begin
               case (mode_i)
                  2'd0:    ready_d = 1'b1;
                  2'd1:    ready_d = 1'b0;
                  2'd2:    ready_d = lfsr_nxt[0];
                  default: ready_d = (per_q == PerLast);
               endcase
            end
         end

         StIdle, StDone: begin
            if (start_i) begin
               state_d = StRun;
               exp_d   = init_i;
               beat_d  = '0;
               err_d   = '0;
               flag_d  = 1'b0;
               fed_d   = '0;
               fee_d   = '0;
               proto_d = 1'b0;
               lfsr_d  = LFSR_SEED;
               per_d   = '0;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State register with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ready_q <= 1'b0;
         exp_q   <= '0;
         beat_q  <= '0;
         err_q   <= '0;
         flag_q  <= 1'b0;
         fed_q   <= '0;
         fee_q   <= '0;
         proto_q <= 1'b0;
         lfsr_q  <= LFSR_SEED;
         per_q   <= '0;
         stall_q <= 1'b0;
         pdata_q <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         exp_q   <= exp_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         flag_q  <= flag_d;
         fed_q   <= fed_d;
         fee_q   <= fee_d;
         proto_q <= proto_d;
         lfsr_q  <= lfsr_d;
         per_q   <= per_d;
         stall_q <= stall_d;
         pdata_q <= pdata_d;
      end
   end

   assign bus.ready        = ready_q;
   assign busy_o           = (state_q == StRun);
   assign done_o           = (state_q == StDone);
   assign beat_cnt_o       = beat_q;
   assign err_cnt_o        = err_q;
   assign err_flag_o       = flag_q;
   assign first_err_data_o = fed_q;
   assign first_err_exp_o  = fee_q;
   assign proto_err_o      = proto_q;

endmodule

// File: tb/tb_bus_stream_sink.sv
// Randomised bench for bus_stream_sink: two instances (RESYNC=0 with 16-bit error counter,
// RESYNC=1 with 4-bit error counter) share stimulus and are compared to a reference model.
module tb_bus_stream_sink;
   localparam int unsigned W   = 32;
   localparam int unsigned CW  = 32;
   localparam int unsigned EW0 = 16;
   localparam int unsigned EW1 = 4;
   localparam int unsigned PER = 4;
   localparam int unsigned LFSR_LEN = 65551;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    mode;
   logic [CW-1:0] len;
   logic [W-1:0]  init;
   logic          valid;
   logic [W-1:0]  data;

   logic           busy0, done0, flag0, proto0;
   logic [CW-1:0]  beat0;
   logic [EW0-1:0] err0;
   logic [W-1:0]   fed0, fee0;
   logic           busy1, done1, flag1, proto1;
   logic [CW-1:0]  beat1;
   logic [EW1-1:0] err1;
   logic [W-1:0]   fed1, fee1;

   bus_stream_sink_if #(.WIDTH(W)) bus0 ();
   bus_stream_sink_if #(.WIDTH(W)) bus1 ();
   assign bus0.valid = valid;
   assign bus0.data  = data;
   assign bus1.valid = valid;
   assign bus1.data  = data;

   bus_stream_sink #(
      .WIDTH(W), .CNT_W(CW), .ERR_W(EW0), .LFSR_SEED(16'hACE1), .PERIOD(PER), .RESYNC(1'b0)
   ) u_dut0 (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .len_i(len), .init_i(init),
      .bus(bus0), .busy_o(busy0), .done_o(done0), .beat_cnt_o(beat0), .err_cnt_o(err0),
      .err_flag_o(flag0), .first_err_data_o(fed0), .first_err_exp_o(fee0),
      .proto_err_o(proto0)
   );

   bus_stream_sink #(
      .WIDTH(W), .CNT_W(CW), .ERR_W(EW1), .LFSR_SEED(16'hACE1), .PERIOD(PER), .RESYNC(1'b1)
   ) u_dut1 (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .len_i(len), .init_i(init),
      .bus(bus1), .busy_o(busy1), .done_o(done1), .beat_cnt_o(beat1), .err_cnt_o(err1),
      .err_flag_o(flag1), .first_err_data_o(fed1), .first_err_exp_o(fee1),
      .proto_err_o(proto1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (shared control, per-instance scoreboard).
   bit           lseq [LFSR_LEN];
   int           m_st;        // 0 idle, 1 run, 2 done
   int           m_n;         // RUN cycle index since start
   bit           m_ready, m_xfer, m_stall, m_proto;
   logic [W-1:0] m_pdata;
   logic [CW-1:0] m_beat;
   logic [W-1:0] m_exp  [2];
   logic [W-1:0] m_fed  [2];
   logic [W-1:0] m_fee  [2];
   int unsigned  m_err  [2];
   bit           m_flag [2];
   int unsigned  err_max [2] = '{65535, 15};
   bit           resync  [2] = '{1'b0, 1'b1};

   logic [W-1:0] src_q [$];
   logic [15:0]  seed = 16'hACE1;

   logic [1:0]    r_m0, r_m1;
   logic [CW-1:0] r_len;
   logic [W-1:0]  r_init;
   int            r_sw, r_vp, r_rs;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
      end
   endtask

   // Ready for RUN cycle n+1 given the mode seen during cycle n.
   function automatic bit pattern(input logic [1:0] m, input int n);
      case (m)
         2'd0:    return 1'b1;
         2'd1:    return 1'b0;
         2'd2:    return lseq[16 + (n % 65535)];
         default: return (n % PER) == (PER - 1);
      endcase
   endfunction

   task automatic model_reset();
      m_st = 0; m_n = 0; m_ready = 0; m_xfer = 0; m_stall = 0; m_proto = 0;
      m_pdata = '0; m_beat = '0;
      for (int r = 0; r < 2; r++) begin
         m_exp[r] = '0; m_fed[r] = '0; m_fee[r] = '0; m_err[r] = 0; m_flag[r] = 0;
      end
   endtask

   task automatic model_step();
      bit term;
      bit mis;
      m_xfer = 0;
      term   = 0;
      if (m_st != 1) begin
         m_ready = 0;
         m_stall = 0;
         if (start) begin
            m_st = 1; m_n = 0; m_beat = '0; m_proto = 0;
            for (int r = 0; r < 2; r++) begin
               m_exp[r] = init; m_err[r] = 0; m_flag[r] = 0; m_fed[r] = '0; m_fee[r] = '0;
            end
         end
      end else begin
         if (m_stall && (!valid || data != m_pdata)) m_proto = 1;
         m_stall = valid && !m_ready;
         m_pdata = data;
         m_xfer  = valid && m_ready;
         if (m_xfer) begin
            for (int r = 0; r < 2; r++) begin
               mis = (data != m_exp[r]);
               if (mis) begin
                  if (m_err[r] < err_max[r]) m_err[r]++;
                  if (!m_flag[r]) begin
                     m_fed[r] = data; m_fee[r] = m_exp[r]; m_flag[r] = 1;
                  end
               end
               m_exp[r] = (mis && resync[r]) ? data + 32'd1 : m_exp[r] + 32'd1;
            end
            term = (len != 0) && (m_beat == len - 1);
            m_beat = m_beat + 1;
         end
         if (term) begin
            m_st = 2; m_ready = 0;
         end else begin
            m_ready = pattern(mode, m_n);
         end
         m_n++;
      end
   endtask

   task automatic check_all();
      check_eq("ready0", 64'(bus0.ready), 64'(m_ready));
      check_eq("ready1", 64'(bus1.ready), 64'(m_ready));
      check_eq("busy0", 64'(busy0), 64'(m_st == 1));
      check_eq("busy1", 64'(busy1), 64'(m_st == 1));
      check_eq("done0", 64'(done0), 64'(m_st == 2));
      check_eq("done1", 64'(done1), 64'(m_st == 2));
      check_eq("beat0", 64'(beat0), 64'(m_beat));
      check_eq("beat1", 64'(beat1), 64'(m_beat));
      check_eq("err0", 64'(err0), 64'(m_err[0]));
      check_eq("err1", 64'(err1), 64'(m_err[1]));
      check_eq("flag0", 64'(flag0), 64'(m_flag[0]));
      check_eq("flag1", 64'(flag1), 64'(m_flag[1]));
      check_eq("fed0", 64'(fed0), 64'(m_fed[0]));
      check_eq("fed1", 64'(fed1), 64'(m_fed[1]));
      check_eq("fee0", 64'(fee0), 64'(m_fee[0]));
      check_eq("fee1", 64'(fee1), 64'(m_fee[1]));
      check_eq("proto0", 64'(proto0), 64'(m_proto));
      check_eq("proto1", 64'(proto1), 64'(m_proto));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      #1;
      check_all();
   endtask

   // Reset asserted between clock edges; outputs must clear without waiting for a clock.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all();
   endtask

   task automatic fill_seq(input logic [W-1:0] ini, input int n, input int corrupt_pct);
      logic [W-1:0] v;
      src_q.delete();
      for (int k = 0; k < n; k++) begin
         v = ini + W'(k);
         if ($urandom_range(99) < corrupt_pct) v = $urandom;
         src_q.push_back(v);
      end
   endtask

   // One run: start pulse then ncyc cycles of a compliant source fed from src_q, with
   // optional mode switch, one injected protocol violation and a stray start pulse.
   task automatic run_seq(input logic [1:0] m0, input logic [1:0] m1, input int sw,
                          input logic [CW-1:0] l, input logic [W-1:0] ini, input int ncyc,
                          input int vprob, input int viol_at, input int viol_kind,
                          input int restart_at);
      int idx;
      bit hold;
      bit violated;
      if (m_st == 1) async_reset();
      mode = m0; len = l; init = ini; valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      idx = 0; hold = 0; violated = 0;
      for (int c = 0; c < ncyc; c++) begin
         mode  = (c >= sw) ? m1 : m0;
         start = (c == restart_at);
         if (!hold) begin
            if (m_st == 1 && idx < src_q.size() && $urandom_range(99) < vprob) begin
               valid = 1'b1;
               data  = src_q[idx];
            end else begin
               valid = 1'b0;
            end
         end
         if (hold && !violated && viol_at >= 0 && c >= viol_at) begin
            violated = 1;
            if (viol_kind == 0) valid = 1'b0;
            else data = data ^ 32'h1;
         end
         tick();
         if (m_xfer) idx++;
         hold = valid && !m_xfer && (m_st == 1);
      end
      start = 1'b0;
      valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) lseq[i] = seed[15-i];
      for (int i = 16; i < LFSR_LEN; i++) lseq[i] = lseq[i-16] ^ lseq[i-14] ^ lseq[i-13] ^ lseq[i-11];

      rst = 1'b1; start = 1'b0; mode = 2'd0; len = '0; init = '0; valid = 1'b0; data = '0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_all();

      // Valid while idle is ignored.
      valid = 1'b1; data = 32'h55;
      repeat (3) tick();
      valid = 1'b0;

      // Back-to-back run of 8 beats.
      fill_seq(32'h10, 8, 0);
      run_seq(2'd0, 2'd0, 1000, 32'd8, 32'h10, 12, 100, -1, 0, -1);
      check_eq("tp1_beat", 64'(beat0), 64'd8);
      check_eq("tp1_err", 64'(err0), 64'd0);
      check_eq("tp1_done", 64'(done0), 64'd1);
      check_eq("tp1_ready", 64'(bus0.ready), 64'd0);

      // Data 0,1,5,3: fixed stride misses beat 2 only, resync also misses beat 3.
      src_q = {32'd0, 32'd1, 32'd5, 32'd3};
      run_seq(2'd0, 2'd0, 1000, 32'd4, 32'd0, 8, 100, -1, 0, -1);
      check_eq("tp2_err0", 64'(err0), 64'd1);
      check_eq("tp2_fed0", 64'(fed0), 64'd5);
      check_eq("tp2_fee0", 64'(fee0), 64'd2);
      check_eq("tp2_err1", 64'(err1), 64'd2);
      check_eq("tp2_fed1", 64'(fed1), 64'd5);
      check_eq("tp2_fee1", 64'(fee1), 64'd2);

      // Periodic ready, unlimited length.
      fill_seq(32'h100, 200, 0);
      run_seq(2'd3, 2'd3, 1000, 32'd0, 32'h100, 40, 100, -1, 0, -1);
      check_eq("tp3_beat_range", 64'(beat0 >= 9 && beat0 <= 11), 64'd1);
      check_eq("tp3_proto", 64'(proto0), 64'd0);

      // Protocol violations under random backpressure: drop valid, then change data.
      fill_seq(32'h200, 200, 0);
      run_seq(2'd2, 2'd2, 1000, 32'd12, 32'h200, 60, 100, 2, 0, -1);
      check_eq("tp4_drop", 64'(proto0), 64'd1);
      run_seq(2'd2, 2'd2, 1000, 32'd12, 32'h200, 60, 100, 2, 1, -1);
      check_eq("tp4_change", 64'(proto1), 64'd1);
      run_seq(2'd2, 2'd2, 1000, 32'd12, 32'h200, 60, 100, -1, 0, -1);
      check_eq("tp4_clear", 64'(proto0), 64'd0);

      // Never-ready for 20 cycles, then always-ready.
      fill_seq(32'h300, 200, 0);
      run_seq(2'd1, 2'd0, 20, 32'd0, 32'h300, 30, 100, -1, 0, -1);
      check_eq("tp5_beat", 64'(beat0), 64'd9);

      // Reset mid-run after 3 beats, then a fresh run.
      fill_seq(32'h400, 200, 0);
      run_seq(2'd0, 2'd0, 1000, 32'd0, 32'h400, 4, 100, -1, 0, -1);
      check_eq("tp6_pre_beat", 64'(beat0), 64'd3);
      async_reset();
      check_eq("tp6_ready", 64'(bus0.ready), 64'd0);
      check_eq("tp6_busy", 64'(busy0), 64'd0);
      check_eq("tp6_beat", 64'(beat0), 64'd0);
      run_seq(2'd0, 2'd0, 1000, 32'd5, 32'h400, 10, 100, -1, 0, -1);
      check_eq("tp6_fresh_beat", 64'(beat0), 64'd5);

      // Random data: every beat misses, narrow counter must saturate.
      fill_seq(32'h0, 40, 100);
      run_seq(2'd0, 2'd0, 1000, 32'd40, 32'h0, 50, 100, -1, 0, -1);
      check_eq("sat_err1", 64'(err1), 64'hF);

      // Randomised runs.
      for (int t = 0; t < 12; t++) begin
         r_m0   = 2'($urandom_range(3));
         r_m1   = 2'($urandom_range(3));
         r_len  = CW'($urandom_range(20));
         r_init = $urandom;
         r_sw   = $urandom_range(60);
         r_vp   = $urandom_range(100, 40);
         r_rs   = ($urandom_range(1) == 1) ? int'($urandom_range(59)) : -1;
         fill_seq(r_init, 200, 10);
         run_seq(r_m0, r_m1, r_sw, r_len, r_init, 60, r_vp, -1, 0, r_rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
